// File: rtl/keymap_port_sequencer.sv
// keymap_port_sequencer
//   Owns the keymap CPU port of the scancode translator and shares it between
//   the Z80 keymap I/O register (single-byte ops through a one-entry pending
//   slot) and a bulk loader that installs a full keymap image.  Every op is
//   stretched into a level strobe of HOLD_CYC cycles followed by GAP_CYC low
//   cycles, so the translator always sees the request and auto-increments its
//   address on release.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   cpu_write/read/rewind, cpu_din   1-cycle CPU requests and write data
//   cpu_dout, cpu_dout_valid         last byte read, 1-cycle update pulse
//   cpu_busy          CPU op pending/executing or loader session active
//   cpu_overrun       sticky: a CPU request was dropped
//   ld_start          1-cycle pulse: begin a loader session
//   ld_valid/ld_data/ld_ready        loader byte stream handshake
//   ld_active, ld_done               session in progress / 1-cycle end pulse
//   km_din, km_write, km_read, km_rewind, km_dout   translator port
module keymap_port_sequencer #(
  parameter int HOLD_CYC  = 8,
  parameter int GAP_CYC   = 2,
  parameter int MAP_BYTES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_write,
  input  logic       cpu_read,
  input  logic       cpu_rewind,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_dout_valid,
  output logic       cpu_busy,
  output logic       cpu_overrun,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       ld_active,
  output logic       ld_done,
  output logic [7:0] km_din,
  output logic       km_write,
  output logic       km_read,
  output logic       km_rewind,
  input  logic [7:0] km_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_GAP, S_LD_WAIT, S_LD_FINAL
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_READ   = 2'd1,
    OP_REWIND = 2'd2,
    OP_NONE   = 2'd3
  } op_t;

  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYC - 1);
  localparam logic [12:0] MAP_END   = 13'(MAP_BYTES);

  state_t      state, state_n;
  op_t         op;
  logic        op_ld;
  logic [7:0]  tmr;
  logic [12:0] cnt;
  logic        ld_pend;

  logic        slot_vld;
  op_t         slot_op;
  logic [7:0]  slot_data;

  op_t         req_op;
  logic        req_vld, req_multi, ld_req;
  logic        hold_end, gap_end;

  logic        start_op, start_ld;
  op_t         start_kind;
  logic [7:0]  start_data;
  logic        ld_begin, cpu_from_slot, cpu_direct, session_end, byte_xfer;

  // Request decode: rewind > write > read, losers are reported as overrun
  always_comb begin
    req_op = OP_NONE;
    if (cpu_rewind)     req_op = OP_REWIND;
    else if (cpu_write) req_op = OP_WRITE;
    else if (cpu_read)  req_op = OP_READ;
  end

  assign req_vld   = (req_op != OP_NONE);
  assign req_multi = (cpu_rewind & cpu_write) | (cpu_rewind & cpu_read) |
                     (cpu_write & cpu_read);
  assign ld_req    = ld_start & ~ld_active;
  assign hold_end  = (state == S_STROBE) && (tmr == HOLD_LAST);
  assign gap_end   = (state == S_GAP) && (tmr == GAP_LAST);

  // Next-state and op launch
  always_comb begin
    state_n       = state;
    start_op      = 1'b0;
    start_ld      = 1'b0;
    start_kind    = OP_NONE;
    start_data    = slot_data;
    ld_begin      = 1'b0;
    cpu_from_slot = 1'b0;
    cpu_direct    = 1'b0;
    session_end   = 1'b0;
    byte_xfer     = 1'b0;
    case (state)
      S_IDLE: begin
        // A loader start (latched or arriving now) beats any CPU op; an
        // empty slot lets a fresh CPU request launch without a slot bubble.
        if (ld_pend || ld_req) begin
          start_op   = 1'b1;
          start_ld   = 1'b1;
          start_kind = OP_REWIND;
          ld_begin   = 1'b1;
        end else if (slot_vld) begin
          start_op      = 1'b1;
          start_kind    = slot_op;
          start_data    = slot_data;
          cpu_from_slot = 1'b1;
        end else if (req_vld) begin
          start_op   = 1'b1;
          start_kind = req_op;
          start_data = cpu_din;
          cpu_direct = 1'b1;
        end
      end
      S_STROBE: begin
        if (hold_end) state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_end) begin
          if (!op_ld) begin
            state_n = S_IDLE;
          end else if (cnt == MAP_END) begin
            // Full image written: close with a rewind, then end the session
            if (op == OP_REWIND) begin
              state_n     = S_IDLE;
              session_end = 1'b1;
            end else begin
              state_n = S_LD_FINAL;
            end
          end else begin
            state_n = S_LD_WAIT;
          end
        end
      end
      S_LD_WAIT: begin
        if (ld_valid) begin
          start_op   = 1'b1;
          start_ld   = 1'b1;
          start_kind = OP_WRITE;
          start_data = ld_data;
          byte_xfer  = 1'b1;
        end
      end
      S_LD_FINAL: begin
        start_op   = 1'b1;
        start_ld   = 1'b1;
        start_kind = OP_REWIND;
      end
      default: state_n = S_IDLE;
    endcase
    if (start_op) state_n = S_STROBE;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      op             <= OP_NONE;
      op_ld          <= 1'b0;
      tmr            <= '0;
      cnt            <= '0;
      ld_pend        <= 1'b0;
      ld_active      <= 1'b0;
      ld_done        <= 1'b0;
      slot_vld       <= 1'b0;
      slot_op        <= OP_NONE;
      cpu_overrun    <= 1'b0;
      cpu_dout       <= '0;
      cpu_dout_valid <= 1'b0;
      km_din         <= '0;
    end else begin
      state <= state_n;

      if (start_op) begin
        op    <= start_kind;
        op_ld <= start_ld;
        if (start_kind == OP_WRITE) km_din <= start_data;
      end

      if (start_op || hold_end) tmr <= '0;
      else                      tmr <= tmr + 8'd1;

      // Read data is sampled on the final strobe cycle, after the
      // translator has had its worst-case latency to respond.
      cpu_dout_valid <= 1'b0;
      if (hold_end && op == OP_READ) begin
        cpu_dout       <= km_dout;
        cpu_dout_valid <= 1'b1;
      end

      if (session_end)    cnt <= '0;
      else if (byte_xfer) cnt <= cnt + 13'd1;

      if (ld_begin)    ld_active <= 1'b1;
      if (session_end) ld_active <= 1'b0;
      ld_done <= session_end;

      if (ld_begin)    ld_pend <= 1'b0;
      else if (ld_req) ld_pend <= 1'b1;

      if (cpu_from_slot) begin
        slot_vld <= 1'b0;
      end else if (req_vld && !slot_vld && !cpu_direct) begin
        slot_vld <= 1'b1;
        slot_op  <= req_op;
      end

      if ((req_vld && slot_vld) || req_multi) cpu_overrun <= 1'b1;
    end
  end

  // Slot payload needs no reset: it is only read while slot_vld is set
  always_ff @(posedge clk) begin
    if (req_vld && !slot_vld && !cpu_direct) slot_data <= cpu_din;
  end

  assign km_write  = (state == S_STROBE) && (op == OP_WRITE);
  assign km_read   = (state == S_STROBE) && (op == OP_READ);
  assign km_rewind = (state == S_STROBE) && (op == OP_REWIND);
  assign ld_ready  = (state == S_LD_WAIT);
  assign cpu_busy  = (state != S_IDLE) || slot_vld || ld_active;

endmodule

// File: tb/tb_keymap_port_sequencer.sv
// Testbench for keymap_port_sequencer: mock translator with a 4096-byte
// keymap, a reference keymap model that produces the expected strobe/read
// sequence, and a monitor that pops and compares whenever the DUT acts.
module tb_keymap_port_sequencer;

  localparam int HOLD = 8;
  localparam int GAP  = 2;
  localparam int MAP  = 4096;

  localparam int K_W    = 0;
  localparam int K_R    = 1;
  localparam int K_RW   = 2;
  localparam int K_DOUT = 3;
  localparam int K_DONE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_write, cpu_read, cpu_rewind;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout;
  logic       cpu_dout_valid, cpu_busy, cpu_overrun;
  logic       ld_start, ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready, ld_active, ld_done;
  logic [7:0] km_din;
  logic       km_write, km_read, km_rewind;
  logic [7:0] km_dout = 8'h00;

  always #5 clk = ~clk;

  keymap_port_sequencer #(
    .HOLD_CYC(HOLD), .GAP_CYC(GAP), .MAP_BYTES(MAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_rewind(cpu_rewind),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_dout_valid(cpu_dout_valid),
    .cpu_busy(cpu_busy), .cpu_overrun(cpu_overrun),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_active(ld_active), .ld_done(ld_done),
    .km_din(km_din), .km_write(km_write), .km_read(km_read),
    .km_rewind(km_rewind), .km_dout(km_dout)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] ref_mem[4096];
  int         ref_addr = 0;
  logic [7:0] km_mem[4096];
  int         km_addr = 0;
  int         done_cnt = 0;

  // Reference keymap: write stores then advances, read returns then
  // advances, rewind returns the address to 0.
  function automatic void exp_op(int k, logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    expq.push_back(e);
    if (k == K_W) begin
      ref_mem[ref_addr] = d;
      ref_addr = (ref_addr + 1) % 4096;
    end else if (k == K_R) begin
      e.kind = K_DOUT;
      e.data = ref_mem[ref_addr];
      expq.push_back(e);
      ref_addr = (ref_addr + 1) % 4096;
    end else begin
      ref_addr = 0;
    end
  endfunction

  function automatic void exp_done();
    exp_t e;
    e.kind = K_DONE;
    e.data = 8'h00;
    expq.push_back(e);
  endfunction

  // Mock translator: acts on strobe release; read data is garbage for the
  // first five strobe cycles, modelling its response latency.
  int prev_kind = -1;
  int hi_cnt = 0;
  always @(negedge clk) begin
    int cur;
    cur = km_write ? K_W : km_read ? K_R : km_rewind ? K_RW : -1;
    if (!rst_n) begin
      km_addr   = 0;
      prev_kind = -1;
      hi_cnt    = 0;
    end else begin
      if (prev_kind != -1 && cur == -1) begin
        if (prev_kind == K_W) begin
          km_mem[km_addr] = km_din;
          km_addr = (km_addr + 1) % 4096;
        end else if (prev_kind == K_R) begin
          km_addr = (km_addr + 1) % 4096;
        end else begin
          km_addr = 0;
        end
      end
      hi_cnt    = (cur == -1) ? 0 : hi_cnt + 1;
      prev_kind = cur;
    end
    km_dout = (hi_cnt > 0 && hi_cnt < 6) ? 8'($urandom) : km_mem[km_addr];
  end

  // Monitor / scoreboard
  int hi_len = 0;
  int lo_len = 100;
  always @(negedge clk) begin
    exp_t e;
    int   kind;
    if (!rst_n) begin
      hi_len = 0;
      lo_len = 100;
    end else begin
      kind = km_write ? K_W : km_read ? K_R : km_rewind ? K_RW : -1;
      if (kind != -1 && hi_len == 0) begin
        chk("strobe_onehot", int'(km_write) + int'(km_read) + int'(km_rewind), 1);
        chk("strobe_gap", int'(lo_len >= GAP), 1);
        if (expq.size() == 0) chk("unexpected_strobe", kind, -1);
        else begin
          e = expq.pop_front();
          chk("strobe_kind", kind, e.kind);
          if (kind == K_W) chk("km_din", int'(km_din), int'(e.data));
        end
      end
      if (kind != -1) begin
        hi_len++;
        lo_len = 0;
      end else begin
        if (hi_len != 0) chk("strobe_len", hi_len, HOLD);
        hi_len = 0;
        lo_len++;
      end
      if (cpu_dout_valid) begin
        if (expq.size() == 0) chk("unexpected_dout", int'(cpu_dout), -1);
        else begin
          e = expq.pop_front();
          chk("dout_kind", K_DOUT, e.kind);
          chk("cpu_dout", int'(cpu_dout), int'(e.data));
        end
      end
      if (ld_done) begin
        done_cnt++;
        if (expq.size() == 0) chk("unexpected_ld_done", K_DONE, -1);
        else begin
          e = expq.pop_front();
          chk("ld_done_kind", K_DONE, e.kind);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(logic w, logic r, logic rw, logic ls, logic [7:0] d);
    cpu_write  = w;
    cpu_read   = r;
    cpu_rewind = rw;
    ld_start   = ls;
    cpu_din    = d;
    tick();
    cpu_write  = 1'b0;
    cpu_read   = 1'b0;
    cpu_rewind = 1'b0;
    ld_start   = 1'b0;
  endtask

  task automatic cpu_op(int k, logic [7:0] d);
    pulse(k == K_W, k == K_R, k == K_RW, 1'b0, d);
  endtask

  task automatic wait_idle(int lim);
    int n = 0;
    while (cpu_busy && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", int'(cpu_busy), 0);
  endtask

  task automatic stream(int n);
    int sent = 0;
    int cyc  = 0;
    bit xprev = 1'b0;
    while (sent < n && cyc < 70000) begin
      ld_valid = ($urandom_range(0, 7) != 0);
      ld_data  = 8'($urandom);
      @(negedge clk);
      if (xprev) chk("ld_ready_drop", int'(ld_ready), 0);
      xprev = ld_valid && ld_ready;
      if (xprev) begin
        exp_op(K_W, ld_data);
        sent++;
      end
      tick();
      cyc++;
    end
    ld_valid = 1'b0;
    chk("ld_bytes", sent, n);
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_km_write"}, int'(km_write), 0);
    chk({tag, "_km_read"}, int'(km_read), 0);
    chk({tag, "_km_rewind"}, int'(km_rewind), 0);
    chk({tag, "_km_din"}, int'(km_din), 0);
    chk({tag, "_ld_active"}, int'(ld_active), 0);
    chk({tag, "_ld_ready"}, int'(ld_ready), 0);
    chk({tag, "_ld_done"}, int'(ld_done), 0);
    chk({tag, "_cpu_busy"}, int'(cpu_busy), 0);
    chk({tag, "_cpu_dout"}, int'(cpu_dout), 0);
    chk({tag, "_dout_valid"}, int'(cpu_dout_valid), 0);
    chk({tag, "_overrun"}, int'(cpu_overrun), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k, k2, n, done0;
    logic [7:0] d, d2, pend_d;

    for (int i = 0; i < 4096; i++) begin
      km_mem[i]  = 8'($urandom);
      ref_mem[i] = km_mem[i];
    end
    rst_n = 1'b0;
    cpu_write = 1'b0; cpu_read = 1'b0; cpu_rewind = 1'b0; cpu_din = 8'h00;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    chk_quiet("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single write: 8 strobe cycles, 2 gap cycles, idle at cycle 11
    exp_op(K_W, 8'hA5);
    cpu_op(K_W, 8'hA5);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c <= 10) chk("t1_km_write", int'(km_write), int'(c <= 8));
      if (c <= 8) chk("t1_km_din", int'(km_din), 8'hA5);
      if (c >= 10) chk("t1_cpu_busy", int'(cpu_busy), int'(c == 10));
    end
    tick();

    // Read of a known byte at address 0
    exp_op(K_RW, 8'h00);
    cpu_op(K_RW, 8'h00);
    wait_idle(40);
    km_mem[0]  = 8'h3C;
    ref_mem[0] = 8'h3C;
    exp_op(K_R, 8'h00);
    cpu_op(K_R, 8'h00);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("t2_dout_valid", int'(cpu_dout_valid), int'(c == 9));
      if (c == 9) chk("t2_cpu_dout", int'(cpu_dout), 8'h3C);
    end
    tick();
    wait_idle(40);

    // Random CPU ops, sometimes with a second op queued in the slot
    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(0, 9);
      k = (n < 4) ? K_W : (n < 8) ? K_R : K_RW;
      d = 8'($urandom);
      exp_op(k, d);
      cpu_op(k, d);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 6)) tick();
        n  = $urandom_range(0, 9);
        k2 = (n < 4) ? K_W : (n < 8) ? K_R : K_RW;
        d2 = 8'($urandom);
        exp_op(k2, d2);
        cpu_op(k2, d2);
      end
      wait_idle(60);
    end
    chk("rand_overrun", int'(cpu_overrun), 0);

    // Full loader session with a CPU write arriving alongside ld_start
    done0  = done_cnt;
    pend_d = 8'($urandom);
    exp_op(K_RW, 8'h00);
    pulse(1'b1, 1'b0, 1'b0, 1'b1, pend_d);
    chk("t4_overrun_early", int'(cpu_overrun), 0);
    chk("t3_ld_active", int'(ld_active), 1);
    chk("t4_cpu_busy", int'(cpu_busy), 1);
    stream(MAP);
    exp_op(K_RW, 8'h00);
    exp_done();
    exp_op(K_W, pend_d);
    wait_idle(200);
    chk("t3_ld_done_count", done_cnt - done0, 1);
    chk("t3_ld_active_end", int'(ld_active), 0);
    chk("t4_overrun", int'(cpu_overrun), 0);

    // Three CPU writes during a session: first pends, others dropped
    exp_op(K_RW, 8'h00);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    chk("t5_overrun_first", int'(cpu_overrun), 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
    chk("t5_overrun", int'(cpu_overrun), 1);
    stream(3);

    // Reset in the middle of a write strobe
    n = 0;
    while (!km_write && n < 40) begin
      tick();
      n++;
    end
    chk("t6_strobe_seen", int'(km_write), 1);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    expq.delete();
    ref_addr = 0;
    @(negedge clk);
    chk("t6_km_write", int'(km_write), 0);
    chk("t6_km_read", int'(km_read), 0);
    chk("t6_km_rewind", int'(km_rewind), 0);
    chk("t6_ld_active", int'(ld_active), 0);
    chk("t6_cpu_busy", int'(cpu_busy), 0);
    chk("t6_overrun", int'(cpu_overrun), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Simultaneous rewind/write/read: rewind wins, others flagged
    exp_op(K_RW, 8'h00);
    pulse(1'b1, 1'b1, 1'b1, 1'b0, 8'h44);
    chk("t7_overrun", int'(cpu_overrun), 1);
    wait_idle(40);

    n = 0;
    while (expq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("queue_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
